// File: rtl/regfile_bank_if.sv
// Register file access bus: one write port, two read ports, write acknowledge.
interface regfile_bank_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 3
);
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic             re1;
  logic [AW-1:0]    raddr1;
  logic [WIDTH-1:0] rdata1;
  logic             re2;
  logic [AW-1:0]    raddr2;
  logic [WIDTH-1:0] rdata2;
  logic             wr_ack;

  // Datapath side: issues writes and read addresses
  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, wr_ack
  );

  // Register file side
  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2,
    output rdata1, rdata2, wr_ack
  );
endinterface

// File: rtl/regfile_bank.sv
// Multi-word register file: one-hot write decode into per-word enables,
// two combinational read ports, optional hard-wired zero word and write bypass.
module regfile_bank #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 8,
  parameter bit          ZERO_R0 = 1'b1,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_bank_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] wen_c;
  logic             commit_c;
  logic             wr_ack_q;
  logic             wr_ack_d;
  logic             hit1_c;
  logic             hit2_c;
  logic [WIDTH-1:0] rdata1_c;
  logic [WIDTH-1:0] rdata2_c;

  // A write commits unless reset is active or it targets the hard-wired zero word
  assign commit_c = bus.we & ~rst & ~(ZERO_R0 & (bus.waddr == AW'(0)));
  assign wr_ack_d = commit_c;

  // One-hot word enable decode; enables gate data only, never the clock
  always_comb begin
    wen_c = '0;
    if (commit_c) begin
      wen_c[bus.waddr] = 1'b1;
    end
  end

  // Next-state of every word: hold unless its enable is set
  always_comb begin
    mem_d = mem_q;
    for (int unsigned w = 0; w < DEPTH; w++) begin
      if (wen_c[AW'(w)]) begin
        mem_d[w] = bus.wdata;
      end
    end
  end

  // Word storage with synchronous clear; reset drops any concurrent write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned w = 0; w < DEPTH; w++) begin
        mem_q[w] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Write acknowledge: one-cycle pulse after each committed write
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ack_q <= 1'b0;
    end else begin
      wr_ack_q <= wr_ack_d;
    end
  end

  // Read port 1: bypass in-flight write data, zero word reads 0, disabled reads 0
  always_comb begin
    hit1_c   = BYPASS & commit_c & (bus.raddr1 == bus.waddr);
    rdata1_c = '0;
    if (bus.re1) begin
      if (hit1_c) begin
        rdata1_c = bus.wdata;
      end else if (!(ZERO_R0 && (bus.raddr1 == AW'(0)))) begin
        rdata1_c = mem_q[bus.raddr1];
      end
    end
  end

  // Read port 2: identical behaviour, independent address and enable
  always_comb begin
    hit2_c   = BYPASS & commit_c & (bus.raddr2 == bus.waddr);
    rdata2_c = '0;
    if (bus.re2) begin
      if (hit2_c) begin
        rdata2_c = bus.wdata;
      end else if (!(ZERO_R0 && (bus.raddr2 == AW'(0)))) begin
        rdata2_c = mem_q[bus.raddr2];
      end
    end
  end

  assign bus.rdata1 = rdata1_c;
  assign bus.rdata2 = rdata2_c;
  assign bus.wr_ack = wr_ack_q;
endmodule

// File: tb/tb_regfile_bank.sv
// Bench for regfile_bank: reference model of the register file checked every
// cycle, plus directed vectors with literal expected values.
module tb_regfile_bank;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  regfile_bank_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  regfile_bank #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_R0(1'b1), .BYPASS(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] model_mem [DEPTH];
  bit         model_ack;
  bit         armed = 1'b0;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected read value straight from the behavioural rules
  function automatic logic [7:0] exp_read(input logic re, input logic [2:0] ra);
    if (!re) return 8'h00;
    if (bus.we && !rst && bus.waddr != 3'd0 && bus.waddr == ra) return bus.wdata;
    if (ra == 3'd0) return 8'h00;
    return model_mem[ra];
  endfunction

  // Model update on each rising edge
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 8'h00;
      model_ack = 1'b0;
      armed     = 1'b1;
    end else begin
      model_ack = bus.we && (bus.waddr != 3'd0);
      if (model_ack) model_mem[bus.waddr] = bus.wdata;
    end
  end

  // Continuous comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (armed) begin
      chk("cmp_rdata1", bus.rdata1, exp_read(bus.re1, bus.raddr1));
      chk("cmp_rdata2", bus.rdata2, exp_read(bus.re2, bus.raddr2));
      chk("cmp_wr_ack", {7'b0, bus.wr_ack}, {7'b0, model_ack});
    end
  end

  task automatic drive(input logic r, input logic w, input logic [2:0] wa,
                       input logic [7:0] wd, input logic e1, input logic [2:0] a1,
                       input logic e2, input logic [2:0] a2);
    @(posedge clk);
    #1;
    rst        = r;
    bus.we     = w;
    bus.waddr  = wa;
    bus.wdata  = wd;
    bus.re1    = e1;
    bus.raddr1 = a1;
    bus.re2    = e2;
    bus.raddr2 = a2;
  endtask

  task automatic peek();
    @(negedge clk);
    #1;
  endtask

  int acks;

  initial begin
    rst        = 1'b1;
    bus.we     = 1'b0;
    bus.waddr  = '0;
    bus.wdata  = '0;
    bus.re1    = 1'b0;
    bus.raddr1 = '0;
    bus.re2    = 1'b0;
    bus.raddr2 = '0;

    // Reset then sweep both read ports
    for (int a = 0; a < 8; a++) begin
      drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'(a), 1'b1, 3'(a));
      peek();
      chk("rst_rdata1", bus.rdata1, 8'h00);
      chk("rst_rdata2", bus.rdata2, 8'h00);
      chk("rst_wr_ack", {7'b0, bus.wr_ack}, 8'h00);
    end

    // Write 0x11*k to word k, counting acknowledge pulses
    acks = 0;
    for (int k = 1; k < 8; k++) begin
      drive(1'b0, 1'b1, 3'(k), 8'(8'h11 * k), 1'b0, 3'd0, 1'b0, 3'd0);
      peek();
      if (bus.wr_ack === 1'b1) acks++;
    end
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
    peek();
    if (bus.wr_ack === 1'b1) acks++;
    chk("wr_ack_count", 8'(acks), 8'd7);
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'(k), 1'b1, 3'(7 - k));
      peek();
      chk("readback1", bus.rdata1, (k == 0) ? 8'h00 : 8'(8'h11 * k));
      chk("readback2", bus.rdata2, (k == 7) ? 8'h00 : 8'(8'h11 * (7 - k)));
    end

    // Zero word ignores writes and never bypasses
    drive(1'b0, 1'b1, 3'd0, 8'hFF, 1'b1, 3'd0, 1'b0, 3'd0);
    peek();
    chk("r0_bypass", bus.rdata1, 8'h00);
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b0, 3'd0);
    peek();
    chk("r0_rdata", bus.rdata1, 8'h00);
    chk("r0_wr_ack", {7'b0, bus.wr_ack}, 8'h00);

    // Bypass: new data visible before the edge, stored after it
    drive(1'b0, 1'b1, 3'd3, 8'h11, 1'b0, 3'd0, 1'b0, 3'd0);
    drive(1'b0, 1'b1, 3'd3, 8'hA5, 1'b1, 3'd3, 1'b0, 3'd3);
    peek();
    chk("bypass_pre", bus.rdata1, 8'hA5);
    chk("bypass_re_off", bus.rdata2, 8'h00);
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd3);
    peek();
    chk("bypass_post1", bus.rdata1, 8'hA5);
    chk("bypass_post2", bus.rdata2, 8'hA5);
    chk("bypass_ack", {7'b0, bus.wr_ack}, 8'h01);

    // Back-to-back writes to one word: read tracks wdata, last write wins
    drive(1'b0, 1'b1, 3'd2, 8'h01, 1'b1, 3'd2, 1'b0, 3'd0);
    peek();
    chk("b2b_first", bus.rdata1, 8'h01);
    drive(1'b0, 1'b1, 3'd2, 8'h02, 1'b1, 3'd2, 1'b0, 3'd0);
    peek();
    chk("b2b_second", bus.rdata1, 8'h02);
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b1, 3'd4);
    peek();
    chk("b2b_final", bus.rdata1, 8'h02);
    chk("other_word", bus.rdata2, 8'h44);

    // Reset dominates a concurrent write and clears prior contents
    drive(1'b1, 1'b1, 3'd5, 8'h5A, 1'b1, 3'd5, 1'b0, 3'd0);
    peek();
    chk("rst_no_bypass", bus.rdata1, 8'h55);
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 1'b1, 3'd3);
    peek();
    chk("rst_beats_wr", bus.rdata1, 8'h00);
    chk("rst_clears", bus.rdata2, 8'h00);
    chk("rst_beats_ack", {7'b0, bus.wr_ack}, 8'h00);

    // Same address on both ports, only port 1 enabled
    drive(1'b0, 1'b1, 3'd6, 8'h3C, 1'b0, 3'd0, 1'b0, 3'd0);
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 1'b0, 3'd6);
    peek();
    chk("dual_rdata1", bus.rdata1, 8'h3C);
    chk("dual_rdata2", bus.rdata2, 8'h00);
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 1'b1, 3'd6);
    peek();
    chk("dual_same1", bus.rdata1, 8'h3C);
    chk("dual_same2", bus.rdata2, 8'h3C);

    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
    peek();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
